// File: rtl/pulpino_pad_ctrl.sv
// Pad mux / GPIO block: APB registers, input sync + filter, rising-edge IRQs.
// Define PAD_DEBOUNCE_EN to add the per-pad debounce counters (DB_CNT).
module pulpino_pad_ctrl #(
    parameter int N_PADS   = 32,
    parameter int DB_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [11:0]       paddr,
    input  logic [31:0]       pwdata,
    input  logic              pwrite,
    input  logic              psel,
    input  logic              penable,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic [N_PADS-1:0] pad_in_i,
    output logic [N_PADS-1:0] pad_out_o,
    output logic [N_PADS-1:0] pad_oen_o,
    input  logic [N_PADS-1:0] periph_out_i,
    input  logic [N_PADS-1:0] periph_oen_i,
    output logic [N_PADS-1:0] periph_in_o,
    output logic [N_PADS-1:0] gpio_in_o,
    output logic              irq_o
);
    localparam logic [11:0] A_MUX = 12'h000;
    localparam logic [11:0] A_OUT = 12'h004;
    localparam logic [11:0] A_DIR = 12'h008;
    localparam logic [11:0] A_IN  = 12'h00C;
    localparam logic [11:0] A_IEN = 12'h010;
    localparam logic [11:0] A_IST = 12'h014;
    localparam logic [11:0] A_DB  = 12'h018;

    logic [N_PADS-1:0]   mux_q;
    logic [N_PADS-1:0]   gpio_out_q;
    logic [N_PADS-1:0]   gpio_dir_q;
    logic [N_PADS-1:0]   irq_en_q;
    logic [N_PADS-1:0]   irq_status_q;
    logic [N_PADS-1:0]   sync1_q;
    logic [N_PADS-1:0]   sync2_q;
    logic [N_PADS-1:0]   filt_q;
    logic [N_PADS-1:0]   filt_d_q;
    logic [DB_WIDTH-1:0] db_cnt_q;
    logic                irq_q;

    logic                access;
    logic                hit;
    logic                err;
    logic                wr_en;
    logic                sel_mux;
    logic                sel_out;
    logic                sel_dir;
    logic                sel_in;
    logic                sel_ien;
    logic                sel_ist;
    logic                sel_db;
    logic [31:0]         rd;
    logic [N_PADS-1:0]   wdata;
    logic [N_PADS-1:0]   irq_set;
    logic [N_PADS-1:0]   irq_clr;

    assign access = psel & penable;
    assign wdata  = pwdata[N_PADS-1:0];

    // Full 12-bit match, so misaligned offsets are unmapped too.
    always_comb begin
        sel_mux = 1'b0;
        sel_out = 1'b0;
        sel_dir = 1'b0;
        sel_in  = 1'b0;
        sel_ien = 1'b0;
        sel_ist = 1'b0;
        sel_db  = 1'b0;
        case (paddr)
            A_MUX:   sel_mux = 1'b1;
            A_OUT:   sel_out = 1'b1;
            A_DIR:   sel_dir = 1'b1;
            A_IN:    sel_in  = 1'b1;
            A_IEN:   sel_ien = 1'b1;
            A_IST:   sel_ist = 1'b1;
            A_DB:    sel_db  = 1'b1;
            default: ;
        endcase
    end

    assign hit = sel_mux | sel_out | sel_dir | sel_in |
                 sel_ien | sel_ist | sel_db;
    assign err     = ~hit | (pwrite & sel_in);
    assign wr_en   = access & pwrite & ~err;
    assign pready  = 1'b1;
    assign pslverr = access & err;

    // Read mux; bits above the implemented width stay 0.
    always_comb begin
        rd = '0;
        unique case (1'b1)
            sel_mux: rd[N_PADS-1:0]   = mux_q;
            sel_out: rd[N_PADS-1:0]   = gpio_out_q;
            sel_dir: rd[N_PADS-1:0]   = gpio_dir_q;
            sel_in:  rd[N_PADS-1:0]   = filt_q;
            sel_ien: rd[N_PADS-1:0]   = irq_en_q;
            sel_ist: rd[N_PADS-1:0]   = irq_status_q;
            sel_db:  rd[DB_WIDTH-1:0] = db_cnt_q;
            default: ;
        endcase
    end

    assign prdata = (access & ~pwrite & ~err) ? rd : 32'h0;

    // Plain RW control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mux_q      <= '0;
            gpio_out_q <= '0;
            gpio_dir_q <= '0;
            irq_en_q   <= '0;
        end else if (wr_en) begin
            if (sel_mux) mux_q      <= wdata;
            if (sel_out) gpio_out_q <= wdata;
            if (sel_dir) gpio_dir_q <= wdata;
            if (sel_ien) irq_en_q   <= wdata;
        end
    end

    // Two-flop synchronizer on every pad input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pad_in_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef PAD_DEBOUNCE_EN
    logic [DB_WIDTH-1:0] cnt_q [N_PADS];

    // DB_CNT register; live counters pick up a new value immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt_q <= '0;
        end else if (wr_en && sel_db) begin
            db_cnt_q <= pwdata[DB_WIDTH-1:0];
        end
    end

    // Debounce: level follows sync2 once it has differed for DB_CNT cycles.
    // >= lets a counter already past a lowered DB_CNT still commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= '0;
            for (int i = 0; i < N_PADS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_PADS; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] >= db_cnt_q) begin
                    filt_q[i] <= sync2_q[i];
                    cnt_q[i]  <= '0;
                end else if (cnt_q[i] != '1) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end
`else
    assign db_cnt_q = '0;

    // No debounce: filtered level is sync2 delayed by one flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= '0;
        end else begin
            filt_q <= sync2_q;
        end
    end
`endif

    assign irq_set = filt_q & ~filt_d_q & irq_en_q;
    assign irq_clr = (wr_en && sel_ist) ? wdata : '0;

    // Edge detect, W1C status (a coincident set wins), registered irq.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_d_q     <= '0;
            irq_status_q <= '0;
            irq_q        <= 1'b0;
        end else begin
            filt_d_q     <= filt_q;
            irq_status_q <= (irq_status_q & ~irq_clr) | irq_set;
            irq_q        <= |(irq_status_q & irq_en_q);
        end
    end

    assign pad_out_o   = (mux_q & periph_out_i) | (~mux_q & gpio_out_q);
    assign pad_oen_o   = (mux_q & periph_oen_i) | (~mux_q & ~gpio_dir_q);
    assign periph_in_o = pad_in_i & mux_q;
    assign gpio_in_o   = filt_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_pulpino_pad_ctrl.sv
// Directed bench for pulpino_pad_ctrl with a scoreboard for APB reads.
// Debounce-specific steps are enabled by PAD_DEBOUNCE_EN.
module tb_pulpino_pad_ctrl;
`ifdef PAD_DEBOUNCE_EN
    localparam int DB_A = 4;
    localparam int DB_B = 10;
`else
    localparam int DB_A = 0;
    localparam int DB_B = 0;
`endif
    localparam int LAT_A = 3 + DB_A;
    localparam int LAT_B = 3 + DB_B;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [31:0] pad_in_i;
    logic [31:0] pad_out_o;
    logic [31:0] pad_oen_o;
    logic [31:0] periph_out_i;
    logic [31:0] periph_oen_i;
    logic [31:0] periph_in_o;
    logic [31:0] gpio_in_o;
    logic        irq_o;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic seen;

    pulpino_pad_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .paddr        (paddr),
        .pwdata       (pwdata),
        .pwrite       (pwrite),
        .psel         (psel),
        .penable      (penable),
        .prdata       (prdata),
        .pready       (pready),
        .pslverr      (pslverr),
        .pad_in_i     (pad_in_i),
        .pad_out_o    (pad_out_o),
        .pad_oen_o    (pad_oen_o),
        .periph_out_i (periph_out_i),
        .periph_oen_i (periph_oen_i),
        .periph_in_o  (periph_in_o),
        .gpio_in_o    (gpio_in_o),
        .irq_o        (irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts and ends on a negedge; the write edge is the 2nd posedge.
    task automatic apb(input bit wr, input logic [11:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd,
                       input bit exp_err, input string tag);
        exp_t e;
        sb.push_back('{rdata: exp_rd, err: exp_err});
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
        @(negedge clk);
        penable = 1'b1;
        #1;
        e = sb.pop_front();
        chk({tag, ".prdata"}, prdata, e.rdata);
        chk({tag, ".pslverr"}, {31'b0, pslverr}, {31'b0, e.err});
        chk({tag, ".pready"}, {31'b0, pready}, 32'h1);
        @(negedge clk);
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d,
                      input string tag);
        apb(1'b1, a, d, 32'h0, 1'b0, tag);
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp,
                      input string tag);
        apb(1'b0, a, 32'h0, exp, 1'b0, tag);
    endtask

    initial begin
        rst          = 1'b1;
        psel         = 1'b0;
        penable      = 1'b0;
        pwrite       = 1'b0;
        paddr        = '0;
        pwdata       = '0;
        pad_in_i     = '1;
        periph_out_i = '0;
        periph_oen_i = '1;
        repeat (3) @(negedge clk);
        chk("rst.oen", pad_oen_o, 32'hFFFF_FFFF);
        chk("rst.out", pad_out_o, 32'h0);
        chk("rst.pin", periph_in_o, 32'h0);
        chk("rst.irq", {31'b0, irq_o}, 32'h0);
        chk("rst.prdata", prdata, 32'h0);
        chk("rst.gin", gpio_in_o, 32'h0);
        pad_in_i = '0;
        rst      = 1'b0;

        for (int i = 0; i < 7; i++) begin
            rd(12'(i * 4), 32'h0, "rd0");
        end
        chk("idle.oen", pad_oen_o, 32'hFFFF_FFFF);

        wr(12'h008, 32'h1, "wr.dir");
        wr(12'h004, 32'h1, "wr.out");
        periph_out_i[1] = 1'b1;
        periph_oen_i[1] = 1'b0;
        wr(12'h000, 32'h2, "wr.mux");
        chk("mux.out", pad_out_o, 32'h3);
        chk("mux.oen", pad_oen_o, 32'hFFFF_FFFC);
        pad_in_i = '1;
        #1;
        chk("mux.pin", periph_in_o, 32'h2);
        pad_in_i = '0;
        rd(12'h000, 32'h2, "rd.mux");

        wr(12'h018, 32'h104, "wr.db");
        rd(12'h018, 32'(DB_A), "rd.db");
        wr(12'h010, 32'h8, "wr.ien");
        repeat (20) @(negedge clk);

`ifdef PAD_DEBOUNCE_EN
        pad_in_i[3] = 1'b1;
        repeat (DB_A) @(negedge clk);
        pad_in_i[3] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen = seen | gpio_in_o[3];
        end
        chk("glitch.gin", {31'b0, seen}, 32'h0);
        rd(12'h014, 32'h0, "glitch.ist");
`endif

        pad_in_i[3] = 1'b1;
        repeat (LAT_A - 1) @(negedge clk);
        chk("lat.before", {31'b0, gpio_in_o[3]}, 32'h0);
        @(negedge clk);
        chk("lat.at", {31'b0, gpio_in_o[3]}, 32'h1);
        rd(12'h00C, 32'h8, "rd.in");
        chk("irq.set", {31'b0, irq_o}, 32'h1);
        rd(12'h014, 32'h8, "rd.ist");

        pad_in_i[3] = 1'b0;
        repeat (20) @(negedge clk);
        rd(12'h014, 32'h8, "fall.ist");
        pad_in_i[3] = 1'b1;
        repeat (LAT_A - 1) @(negedge clk);
        wr(12'h014, 32'h8, "w1c.coinc");
        rd(12'h014, 32'h8, "coinc.ist");
        chk("coinc.irq", {31'b0, irq_o}, 32'h1);

        wr(12'h010, 32'h0, "ien.off");
        @(negedge clk);
        chk("ienoff.irq", {31'b0, irq_o}, 32'h0);
        rd(12'h014, 32'h8, "ienoff.ist");
        wr(12'h010, 32'h8, "ien.on");
        @(negedge clk);
        chk("ienon.irq", {31'b0, irq_o}, 32'h1);
        wr(12'h014, 32'h8, "w1c.lone");
        @(negedge clk);
        chk("lone.irq", {31'b0, irq_o}, 32'h0);
        rd(12'h014, 32'h0, "lone.ist");

        apb(1'b0, 12'h01C, 32'h0, 32'h0, 1'b1, "err.rd1c");
        apb(1'b1, 12'h00C, 32'hFFFF_FFFF, 32'h0, 1'b1, "err.wrin");
        apb(1'b1, 12'h01C, 32'h5, 32'h0, 1'b1, "err.wr1c");
        apb(1'b0, 12'h002, 32'h0, 32'h0, 1'b1, "err.misal");
        rd(12'h000, 32'h2, "err.mux");
        rd(12'h00C, 32'h8, "err.in");
        rd(12'h010, 32'h8, "err.ien");
        rd(12'h004, 32'h1, "err.out");

        wr(12'h018, 32'd10, "wr.db10");
        pad_in_i = '0;
        repeat (20) @(negedge clk);
        pad_in_i[3] = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid.gin", gpio_in_o, 32'h0);
        chk("mid.oen", pad_oen_o, 32'hFFFF_FFFF);
        chk("mid.irq", {31'b0, irq_o}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        pad_in_i = '0;
        rst      = 1'b0;
        rd(12'h018, 32'h0, "post.db");
        rd(12'h00C, 32'h0, "post.in");
        rd(12'h000, 32'h0, "post.mux");
        wr(12'h018, 32'd10, "wr.db10b");
        pad_in_i[3] = 1'b1;
        repeat (LAT_B - 1) @(negedge clk);
        chk("full.before", {31'b0, gpio_in_o[3]}, 32'h0);
        @(negedge clk);
        chk("full.at", {31'b0, gpio_in_o[3]}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
